// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// The error-response pattern here is used only when DMEM_RANGE_ERR_EN is defined.
package dmem_pkg;
  localparam int DATA_W     = 16;
  localparam int REQ_ADDR_W = 16;
  localparam logic [DATA_W-1:0] ERR_RDATA = 16'hDEAD;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;
endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM with a registered read port.
// rdata is zero unless the previous edge performed an enabled read.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Array contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (en_i && we_i) mem_q[addr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              rdata_q <= '0;
    else if (en_i && !we_i)  rdata_q <= mem_q[addr_i];
    else                     rdata_q <= '0;
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: IDLE -> WAIT (WAIT_STATES cycles) -> RESP, one access at a time.
// Define DMEM_RANGE_ERR_EN to add rsp_err for addresses beyond the RAM depth.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [REQ_ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
`ifdef DMEM_RANGE_ERR_EN
  output logic                  rsp_err,
`endif
  output logic                  stall
);
  localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rsp_valid_q;
  logic              req_ready_q;

  logic              accept;
  logic              enter_resp;
  logic              cur_wr;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic              ram_en;
  logic [DATA_W-1:0] ram_rdata;

  assign accept     = req_valid && req_ready_q;
  assign enter_resp = ((state_q == IDLE) && accept && (WAIT_STATES == 0)) ||
                      ((state_q == WAIT) && (cnt_q == '0));

  // With zero wait states the RAM is touched on the accept edge, before the latches hold the request.
  assign cur_wr    = (state_q == IDLE) ? req_write                : wr_q;
  assign cur_addr  = (state_q == IDLE) ? req_addr[ADDR_W-1:0]     : addr_q;
  assign cur_wdata = (state_q == IDLE) ? req_wdata                : wdata_q;

`ifdef DMEM_RANGE_ERR_EN
  logic oor_q;
  logic rsp_err_q;
  logic cur_oor;

  assign cur_oor = (state_q == IDLE) ? (|req_addr[REQ_ADDR_W-1:ADDR_W]) : oor_q;
  assign ram_en  = enter_resp && !cur_oor;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      oor_q     <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      if (accept) oor_q <= |req_addr[REQ_ADDR_W-1:ADDR_W];
      rsp_err_q <= enter_resp && cur_oor;
    end
  end

  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = (rsp_err_q && !wr_q) ? ERR_RDATA : ram_rdata;
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[REQ_ADDR_W-1:ADDR_W];
  assign ram_en    = enter_resp;
  assign rsp_rdata = ram_rdata;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      rsp_valid_q <= enter_resp;
      case (state_q)
        IDLE: begin
          if (accept) begin
            wr_q        <= req_write;
            addr_q      <= req_addr[ADDR_W-1:0];
            wdata_q     <= req_wdata;
            req_ready_q <= 1'b0;
            cnt_q       <= CNT_INIT;
            state_q     <= (WAIT_STATES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) state_q <= RESP;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        RESP: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  dmem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .reset   (reset),
    .en_i    (ram_en),
    .we_i    (cur_wr),
    .addr_i  (cur_addr),
    .wdata_i (cur_wdata),
    .rdata_o (ram_rdata)
  );

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign stall     = req_valid && !rsp_valid_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a word-array reference model.
// Honors DMEM_RANGE_ERR_EN when defined for the build.
module tb_dmem_responder;
  localparam int WS = 2;
  localparam int AW = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [15:0] req_addr  = '0;
  logic [15:0] req_wdata = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        stall;
`ifdef DMEM_RANGE_ERR_EN
  logic        rsp_err;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] mem_m [2**AW];
  bit          known [2**AW];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(AW), .WAIT_STATES(WS)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
`ifdef DMEM_RANGE_ERR_EN
    .rsp_err   (rsp_err),
`endif
    .stall     (stall)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic access(input bit wr, input logic [15:0] addr, input logic [15:0] wd,
                        input bit mutate, input bit drop);
    int         lat;
    bit         done;
    bit         err;
    logic [7:0] idx;
    idx = addr[7:0];
`ifdef DMEM_RANGE_ERR_EN
    err = |addr[15:8];
`else
    err = 1'b0;
`endif
    chk("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    #1;
    chk("stall_req", 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    if (mutate) begin
      req_addr  = addr ^ 16'h0003;
      req_wdata = ~wd;
    end
    if (drop) req_valid = 1'b0;
    lat  = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (rsp_valid) done = 1'b1;
      else begin
        chk("ready_wait", 32'(req_ready), 32'd0);
        chk("stall_wait", 32'(stall), drop ? 32'd0 : 32'd1);
        lat++;
      end
    end
    chk("rsp_seen", 32'(done), 32'd1);
    chk("latency", 32'(lat), 32'(WS));
    chk("ready_resp", 32'(req_ready), 32'd0);
    chk("stall_resp", 32'(stall), 32'd0);
    if (wr) begin
      chk("rdata_store", 32'(rsp_rdata), 32'd0);
      if (!err) begin
        mem_m[idx] = wd;
        known[idx] = 1'b1;
      end
    end else if (err) begin
      chk("rdata_err", 32'(rsp_rdata), 32'h0000DEAD);
    end else if (known[idx]) begin
      chk("rdata_load", 32'(rsp_rdata), 32'(mem_m[idx]));
    end
`ifdef DMEM_RANGE_ERR_EN
    chk("rsp_err", 32'(rsp_err), 32'(err));
`endif
    req_valid = 1'b0;
    @(negedge clk);
    chk("valid_pulse", 32'(rsp_valid), 32'd0);
    chk("rdata_clear", 32'(rsp_rdata), 32'd0);
    chk("ready_back", 32'(req_ready), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) known[i] = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    chk("post_rst_valid", 32'(rsp_valid), 32'd0);

    // Store then load back, and input changes ignored after acceptance.
    access(1'b1, 16'h0012, 16'hBEEF, 1'b0, 1'b0);
    access(1'b0, 16'h0012, 16'h0000, 1'b0, 1'b0);
    access(1'b1, 16'h0006, 16'h7777, 1'b0, 1'b0);
    access(1'b1, 16'h0005, 16'h1111, 1'b1, 1'b0);
    access(1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0);
    access(1'b0, 16'h0006, 16'h0000, 1'b0, 1'b0);

    // Reset during the wait phase of a store discards it.
    access(1'b1, 16'h0020, 16'h5555, 1'b0, 1'b0);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 16'h0020;
    req_wdata = 16'hAAAA;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_ready", 32'(req_ready), 32'd1);
    chk("midrst_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rdata", 32'(rsp_rdata), 32'd0);
    chk("midrst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    access(1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0);

    // Upper address bits: alias without the error option, error response with it.
    access(1'b0, 16'h0112, 16'h0000, 1'b0, 1'b0);
    access(1'b1, 16'h0312, 16'h4321, 1'b0, 1'b0);
    access(1'b0, 16'h0012, 16'h0000, 1'b0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      logic [15:0] a;
      a[7:0]  = 8'($urandom_range(0, 15));
      a[15:8] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      access(1'($urandom_range(0, 1)), a, 16'($urandom), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
